// File: rtl/reset_release_sequencer.sv
// rtl/reset_release_sequencer.sv - ordered, spaced release of downstream resets after POR
// Synchronises RST_N deassertion, holds, then releases rst_out_n bits one by one.
module reset_release_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 16,
   parameter int NUM_OUTPUTS = 4,
   parameter int GAP_CYCLES  = 8
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   soft_reset_req,
   output logic [NUM_OUTPUTS-1:0] rst_out_n,
   output logic                   ready
);

   localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);
   localparam int IDX_W   = $clog2(NUM_OUTPUTS + 1);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_DONE  = IDX_W'(NUM_OUTPUTS);

   typedef enum logic [1:0] {
      ST_SYNC,
      ST_HOLD,
      ST_RELEASE,
      ST_READY
   } state_t;

   state_t                   state_q, state_d;
   logic [SYNC_STAGES-1:0]   sync_q, sync_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_inc;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [NUM_OUTPUTS-1:0]   rst_q, rst_d;
   logic                     ready_q, ready_d;

   assign sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_q  <= '0;
         state_q <= ST_SYNC;
         cnt_q   <= '0;
         idx_q   <= '0;
         rst_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rst_q   <= rst_d;
         ready_q <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rst_d   = rst_q;
      ready_d = ready_q;

      if (state_q != ST_SYNC && soft_reset_req) begin
         state_d = ST_HOLD;
         cnt_d   = '0;
         idx_d   = '0;
         rst_d   = '0;
         ready_d = 1'b0;
      end else begin
         case (state_q)
            // Leave SYNC on the same edge that sets the last synchroniser stage.
            ST_SYNC: begin
               if (sync_q[SYNC_STAGES-2]) begin
                  state_d = ST_HOLD;
                  cnt_d   = '0;
               end
            end
            ST_HOLD: begin
               if (cnt_q >= HOLD_LAST && sync_q[SYNC_STAGES-1]) begin
                  rst_d[0] = 1'b1;
                  idx_d    = IDX_W'(1);
                  cnt_d    = '0;
                  state_d  = ST_RELEASE;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            ST_RELEASE: begin
               if (idx_q == IDX_DONE) begin
                  ready_d = 1'b1;
                  state_d = ST_READY;
               end else if (cnt_q >= GAP_LAST) begin
                  for (int k = 0; k < NUM_OUTPUTS; k++) begin
                     if (idx_q == IDX_W'(k)) rst_d[k] = 1'b1;
                  end
                  idx_d = idx_q + 1'b1;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            ST_READY: begin
            end
            default: state_d = ST_SYNC;
         endcase
      end
   end

   assign rst_out_n = rst_q;
   assign ready     = ready_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// tb/tb_reset_release_sequencer.sv - randomized and directed checks of reset_release_sequencer
// Model: outputs derived from edge count since RST_N rise and the latest honoured soft request.
module tb_reset_release_sequencer;

   localparam int S_A = 2, H_A = 16, N_A = 4, G_A = 8;
   localparam int S_B = 3, H_B = 1,  N_B = 1, G_B = 8;

   logic           CLK    = 1'b0;
   logic           RST_N  = 1'b0;
   logic           soft_a = 1'b0;
   logic           soft_b = 1'b0;
   logic [N_A-1:0] rst_a;
   logic [N_B-1:0] rst_b;
   logic           rdy_a, rdy_b;

   int total = 0;
   int bad   = 0;
   int edge_n = 0;
   int base_a = S_A;
   int base_b = S_B;

   reset_release_sequencer #(
      .SYNC_STAGES(S_A), .HOLD_CYCLES(H_A), .NUM_OUTPUTS(N_A), .GAP_CYCLES(G_A)
   ) dut_a (
      .CLK(CLK), .RST_N(RST_N), .soft_reset_req(soft_a), .rst_out_n(rst_a), .ready(rdy_a)
   );

   reset_release_sequencer #(
      .SYNC_STAGES(S_B), .HOLD_CYCLES(H_B), .NUM_OUTPUTS(N_B), .GAP_CYCLES(G_B)
   ) dut_b (
      .CLK(CLK), .RST_N(RST_N), .soft_reset_req(soft_b), .rst_out_n(rst_b), .ready(rdy_b)
   );

   always #5 CLK = ~CLK;

   function automatic int exp_vec(int e, int base, int h, int g, int n);
      int c = 0;
      for (int k = 0; k < n; k++) if (e >= base + h + k * g) c++;
      return (1 << c) - 1;
   endfunction

   function automatic int exp_rdy(int e, int base, int h, int g, int n);
      return (e >= base + h + (n - 1) * g + 1) ? 1 : 0;
   endfunction

   task automatic check(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, edge_n, $time);
      end
   endtask

   // Reference model: edge counter restarts on RST_N, soft requests move the base edge.
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         edge_n = 0;
         base_a = S_A;
         base_b = S_B;
      end else begin
         edge_n++;
         if (soft_a && edge_n > S_A) base_a = edge_n;
         if (soft_b && edge_n > S_B) base_b = edge_n;
      end
   end

   always @(negedge CLK) begin
      check("a_rst", int'(rst_a), exp_vec(edge_n, base_a, H_A, G_A, N_A));
      check("a_rdy", int'(rdy_a), exp_rdy(edge_n, base_a, H_A, G_A, N_A));
      check("b_rst", int'(rst_b), exp_vec(edge_n, base_b, H_B, G_B, N_B));
      check("b_rdy", int'(rdy_b), exp_rdy(edge_n, base_b, H_B, G_B, N_B));
   end

   task automatic at_edge(int n);
      int guard = 0;
      do begin
         @(negedge CLK);
         guard++;
      end while (edge_n < n && guard < 2000);
      check("edge_reach", edge_n, n);
   endtask

   task automatic lit_a(string nm, int v, int r);
      check({nm, "_rst"}, int'(rst_a), v);
      check({nm, "_rdy"}, int'(rdy_a), r);
   endtask

   task automatic restart();
      @(negedge CLK);
      RST_N  = 1'b0;
      soft_a = 1'b0;
      soft_b = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   initial begin
      soft_b = 1'b1;
      #7;
      lit_a("por", 0, 0);
      check("por_b_rst", int'(rst_b), 0);
      @(negedge CLK);
      RST_N = 1'b1;

      at_edge(3);
      check("b_e3_rst", int'(rst_b), 0);
      soft_b = 1'b0;
      at_edge(4);
      check("b_e4_rst", int'(rst_b), 1);
      check("b_e4_rdy", int'(rdy_b), 0);
      at_edge(5);
      check("b_e5_rdy", int'(rdy_b), 1);

      at_edge(17);  lit_a("e17", 0, 0);
      at_edge(18);  lit_a("e18", 1, 0);
      at_edge(26);  lit_a("e26", 3, 0);
      at_edge(34);  lit_a("e34", 7, 0);
      at_edge(42);  lit_a("e42", 15, 0);
      at_edge(43);  lit_a("e43", 15, 1);
      at_edge(99);  soft_a = 1'b1;
      at_edge(100); lit_a("s100", 0, 0); soft_a = 1'b0;
      at_edge(115); lit_a("s115", 0, 0);
      at_edge(116); lit_a("s116", 1, 0);
      at_edge(140); lit_a("s140", 15, 0);
      at_edge(141); lit_a("s141", 15, 1);

      restart();
      at_edge(29); lit_a("m29", 3, 0); soft_a = 1'b1;
      at_edge(30); lit_a("m30", 0, 0); soft_a = 1'b0;
      at_edge(45); lit_a("m45", 0, 0);
      at_edge(46); lit_a("m46", 1, 0);
      at_edge(70); lit_a("m70", 15, 0);
      at_edge(71); lit_a("m71", 15, 1);

      restart();
      at_edge(49); lit_a("h49", 15, 1); soft_a = 1'b1;
      at_edge(59); lit_a("h59", 0, 0);  soft_a = 1'b0;
      at_edge(74); lit_a("h74", 0, 0);
      at_edge(75); lit_a("h75", 1, 0);

      restart();
      at_edge(37); lit_a("g37", 7, 0);
      #1 RST_N = 1'b0;
      #1;
      lit_a("glitch", 0, 0);
      check("glitch_b_rst", int'(rst_b), 0);
      #1 RST_N = 1'b1;
      at_edge(17); lit_a("r17", 0, 0);
      at_edge(18); lit_a("r18", 1, 0);
      at_edge(43); lit_a("r43", 15, 1);

      restart();
      for (int i = 0; i < 3000; i++) begin
         int r;
         @(negedge CLK);
         soft_a = ($urandom_range(0, 79) == 0);
         soft_b = ($urandom_range(0, 19) == 0);
         r = int'($urandom_range(0, 399));
         if (r == 0) begin
            #1 RST_N = 1'b0;
            #($urandom_range(1, 3)) RST_N = 1'b1;
         end else if (r == 1) begin
            #1 RST_N = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge CLK);
            RST_N = 1'b1;
         end
      end

      @(negedge CLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
